// File: rtl/riscv_pkg.sv
// riscv_pkg: shared forwarding-select encodings and register constants
package riscv_pkg;
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: picks the bypass source for one Execute operand, youngest producer first
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       Valid_M,
  input  logic       Valid_W,
  output fwd_e       fwd
);
  logic w_mem, w_wb;
  assign w_mem = (Rs_E != REG_X0) && (Rs_E == Rd_M) && RegWrite_M && Valid_M;
  assign w_wb  = (Rs_E != REG_X0) && (Rs_E == Rd_W) && RegWrite_W && Valid_W;
  // Memory-stage producer is younger, so it takes priority over Writeback
  always_comb fwd = w_mem ? FWD_MEM : w_wb ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, control flush and operand forwarding for a 5-stage pipeline
module hazard_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic [4:0]  Rd_D,
  input  logic        Load_D,
  input  logic        RegWrite_M,
  input  logic        RegWrite_W,
  input  logic        PCSrcE,
  output logic [1:0]  Forward_A_E,
  output logic [1:0]  Forward_B_E,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic [4:0]  r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic        r_load_e, r_valid_e, r_valid_m, r_valid_w;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_lw_stall;
  fwd_e        w_fwd_a, w_fwd_b;

  assign w_lw_stall = r_valid_e && r_load_e && (r_rd_e != REG_X0) &&
                      ((Rs1_D == r_rd_e) || (Rs2_D == r_rd_e));
  assign Stall_F     = w_lw_stall;
  assign Stall_D     = w_lw_stall;
  assign Flush_D     = PCSrcE;
  assign Flush_E     = w_lw_stall || PCSrcE;
  assign Forward_A_E = w_fwd_a;
  assign Forward_B_E = w_fwd_b;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // Execute shadow: a flush inserts an all-zero bubble with Valid cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset || Flush_E) begin
      r_rs1_e   <= '0;
      r_rs2_e   <= '0;
      r_rd_e    <= '0;
      r_load_e  <= 1'b0;
      r_valid_e <= 1'b0;
    end else begin
      r_rs1_e   <= Rs1_D;
      r_rs2_e   <= Rs2_D;
      r_rd_e    <= Rd_D;
      r_load_e  <= Load_D;
      r_valid_e <= 1'b1;
    end
  end

  // Memory and Writeback shadows advance every cycle; those stages never stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_m    <= '0;
      r_valid_m <= 1'b0;
      r_rd_w    <= '0;
      r_valid_w <= 1'b0;
    end else begin
      r_rd_m    <= r_rd_e;
      r_valid_m <= r_valid_e;
      r_rd_w    <= r_rd_m;
      r_valid_w <= r_valid_m;
    end
  end

  // Saturating event counters for load-use stalls and control flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lw_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (PCSrcE && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  fwd_sel u_fwd_a (
    .Rs_E(r_rs1_e), .Rd_M(r_rd_m), .Rd_W(r_rd_w),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .Valid_M(r_valid_m), .Valid_W(r_valid_w), .fwd(w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .Rs_E(r_rs2_e), .Rd_M(r_rd_m), .Rd_W(r_rd_w),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .Valid_M(r_valid_m), .Valid_W(r_valid_w), .fwd(w_fwd_b)
  );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed instruction sequences with hand-computed hazard outputs
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic        Load_D, RegWrite_M, RegWrite_W, PCSrcE;
  logic [1:0]  Forward_A_E, Forward_B_E;
  logic        Stall_F, Stall_D, Flush_D, Flush_E;
  logic [15:0] stall_cnt, flush_cnt;
  int          n_chk = 0;
  int          n_err = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .Load_D(Load_D),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .PCSrcE(PCSrcE),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setd(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic ld);
    Rs1_D = rs1;
    Rs2_D = rs2;
    Rd_D = rd;
    Load_D = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    setd(0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    PCSrcE = 1'b0;
    RegWrite_M = 1'b1;
    RegWrite_W = 1'b1;
    setd(0, 0, 0, 0);
    #12;
    chk("rst_fwd_a", {14'd0, Forward_A_E}, 16'd0);
    chk("rst_fwd_b", {14'd0, Forward_B_E}, 16'd0);
    chk("rst_stall", {15'd0, Stall_F}, 16'd0);
    chk("rst_flush_e", {15'd0, Flush_E}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    PCSrcE = 1'b1;
    #1;
    chk("rst_flush_d", {15'd0, Flush_D}, 16'd1);
    PCSrcE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drain();
    // add x5,x1,x2 ; sub x6,x5,x1 -> MEM bypass on A
    setd(1, 2, 5, 0); tick();
    setd(5, 1, 6, 0); tick();
    chk("mem_fwd_a", {14'd0, Forward_A_E}, 16'd2);
    chk("mem_fwd_b", {14'd0, Forward_B_E}, 16'd0);
    drain();
    // add x5 ; nop ; or x7,x1,x5 -> WB bypass on B
    setd(1, 2, 5, 0); tick();
    setd(0, 0, 0, 0); tick();
    setd(1, 5, 7, 0); tick();
    chk("wb_fwd_b", {14'd0, Forward_B_E}, 16'd1);
    chk("wb_fwd_a", {14'd0, Forward_A_E}, 16'd0);
    drain();
    // add x5 ; add x5 ; sub x6,x5,x5 -> MEM wins over WB; without RegWrite_M falls back to WB
    setd(1, 2, 5, 0); tick();
    setd(3, 4, 5, 0); tick();
    setd(5, 5, 6, 0); tick();
    chk("prio_fwd_a", {14'd0, Forward_A_E}, 16'd2);
    chk("prio_fwd_b", {14'd0, Forward_B_E}, 16'd2);
    RegWrite_M = 1'b0;
    #1;
    chk("nowm_fwd_a", {14'd0, Forward_A_E}, 16'd1);
    RegWrite_M = 1'b1;
    drain();
    // lw x5 ; add x6,x5,x2 -> one stall cycle then WB bypass
    setd(1, 0, 5, 1); tick();
    setd(5, 2, 6, 0);
    chk("lw_stall_f", {15'd0, Stall_F}, 16'd1);
    chk("lw_stall_d", {15'd0, Stall_D}, 16'd1);
    chk("lw_flush_e", {15'd0, Flush_E}, 16'd1);
    chk("lw_flush_d", {15'd0, Flush_D}, 16'd0);
    chk("lw_cnt0", stall_cnt, 16'd0);
    tick();
    chk("lw_unstall", {15'd0, Stall_F}, 16'd0);
    chk("lw_cnt1", stall_cnt, 16'd1);
    tick();
    chk("lw_fwd_a", {14'd0, Forward_A_E}, 16'd1);
    drain();
    // lw x0 ; add x6,x0,x2 -> no stall, no bypass
    setd(1, 0, 0, 1); tick();
    setd(0, 2, 6, 0);
    chk("x0_stall", {15'd0, Stall_F}, 16'd0);
    tick();
    chk("x0_fwd_a", {14'd0, Forward_A_E}, 16'd0);
    chk("x0_cnt", stall_cnt, 16'd1);
    drain();
    // taken branch in E squashes add x5 in D; later x5 reader sees no bypass
    setd(1, 2, 5, 0);
    PCSrcE = 1'b1;
    #1;
    chk("br_flush_d", {15'd0, Flush_D}, 16'd1);
    chk("br_flush_e", {15'd0, Flush_E}, 16'd1);
    tick();
    PCSrcE = 1'b0;
    chk("br_cnt", flush_cnt, 16'd1);
    setd(5, 5, 9, 0); tick();
    chk("br_fwd_a", {14'd0, Forward_A_E}, 16'd0);
    chk("br_fwd_b", {14'd0, Forward_B_E}, 16'd0);
    drain();
    // drive flush_cnt to saturation and one more pulse
    PCSrcE = 1'b1;
    repeat (65534) tick();
    chk("sat_cnt", flush_cnt, 16'hFFFF);
    tick();
    PCSrcE = 1'b0;
    chk("sat_hold", flush_cnt, 16'hFFFF);
    chk("sat_stall_cnt", stall_cnt, 16'd1);
    drain();
    // asynchronous reset in the middle of a load-use stall
    setd(1, 0, 5, 1); tick();
    setd(5, 2, 6, 0);
    chk("pre_rst_stall", {15'd0, Stall_F}, 16'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_stall", {15'd0, Stall_F}, 16'd0);
    chk("arst_flush_e", {15'd0, Flush_E}, 16'd0);
    chk("arst_stall_cnt", stall_cnt, 16'd0);
    chk("arst_flush_cnt", flush_cnt, 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
